// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit.
// Fetch side: a table of 2-bit saturating counters indexed by word-address
// bits of the PC gives a zero-latency taken/not-taken guess.
// Execute side: each resolving branch is evaluated, the counter is trained,
// and a registered redirect is raised for one cycle on a mispredict.
// Saturating event counters track resolved branches and mispredicts.

module branch_predict_unit #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CTR_INIT   = 2'b01,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] fetchPC,
  output logic                  predTaken,

  input  logic                  resValid,
  input  logic [ADDR_WIDTH-1:0] resPC,
  input  logic [1:0]            resBrCode,
  input  logic [DATA_WIDTH-1:0] resRS,
  input  logic [DATA_WIDTH-1:0] resRT,
  input  logic [15:0]           resDisp,
  input  logic                  resPredTaken,

  output logic                  redirectValid,
  output logic [ADDR_WIDTH-1:0] redirectPC,
  output logic [CNT_WIDTH-1:0]  branchCount,
  output logic [CNT_WIDTH-1:0]  mispredCount
);

  localparam int DEPTH = 1 << INDEX_BITS;

  // Branch condition codes carried down the pipe.
  localparam logic [1:0] BR_NONE  = 2'd0;
  localparam logic [1:0] BR_EQ    = 2'd1;
  localparam logic [1:0] BR_NE    = 2'd2;
  localparam logic [1:0] BR_TAKEN = 2'd3;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  state_e                  state_q;
  state_e                  state_d;

  logic [1:0]              ctrTable_q [DEPTH];

  logic [INDEX_BITS-1:0]   fetchIdx;
  logic [INDEX_BITS-1:0]   resIdx;
  logic [1:0]              resCtr;
  logic [1:0]              resCtrNext;

  logic                    accepted;
  logic                    taken;
  logic                    mispredict;

  logic [ADDR_WIDTH-1:0]   fallPC;
  logic [ADDR_WIDTH-1:0]   dispOffset;
  logic [ADDR_WIDTH-1:0]   targetPC;
  logic [ADDR_WIDTH-1:0]   correctPC;

  logic [ADDR_WIDTH-1:0]   redirectPC_q;
  logic [ADDR_WIDTH-1:0]   redirectPC_d;
  logic [CNT_WIDTH-1:0]    branchCount_q;
  logic [CNT_WIDTH-1:0]    branchCount_d;
  logic [CNT_WIDTH-1:0]    mispredCount_q;
  logic [CNT_WIDTH-1:0]    mispredCount_d;

  // Only the word-index bits of the fetch PC select a counter; the rest
  // are deliberately ignored, so distinct PCs may alias onto one counter.
  logic                    unusedFetchBits;

  assign fetchIdx        = fetchPC[INDEX_BITS+1:2];
  assign resIdx          = resPC[INDEX_BITS+1:2];
  assign unusedFetchBits = ^{fetchPC[ADDR_WIDTH-1:INDEX_BITS+2], fetchPC[1:0]};

  // Zero-latency prediction straight from the table, held low during reset.
  always_comb begin
    predTaken = 1'b0;
    if (!rst) begin
      predTaken = ctrTable_q[fetchIdx][1];
    end
  end

  // Evaluate the resolving branch: acceptance, direction and correct next PC.
  // Resolves arriving while a redirect is out are on the wrong path.
  always_comb begin
    accepted   = resValid && (resBrCode != BR_NONE) && (state_q == IDLE);

    taken      = 1'b0;
    case (resBrCode)
      BR_EQ:    taken = (resRS == resRT);
      BR_NE:    taken = (resRS != resRT);
      BR_TAKEN: taken = 1'b1;
      default:  taken = 1'b0;
    endcase

    fallPC     = resPC + ADDR_WIDTH'(4);
    dispOffset = {{(ADDR_WIDTH-18){resDisp[15]}}, resDisp, 2'b00};
    targetPC   = fallPC + dispOffset;
    correctPC  = taken ? targetPC : fallPC;

    mispredict = accepted && (taken != resPredTaken);
  end

  // Saturating 2-bit training step for the counter of the resolving branch.
  always_comb begin
    resCtr     = ctrTable_q[resIdx];
    resCtrNext = resCtr;
    if (taken) begin
      if (resCtr != 2'b11) begin
        resCtrNext = resCtr + 2'd1;
      end
    end else begin
      if (resCtr != 2'b00) begin
        resCtrNext = resCtr - 2'd1;
      end
    end
  end

  // Next-state logic: a mispredict opens a one-cycle redirect window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values for the redirect target and the saturating event counters.
  always_comb begin
    redirectPC_d   = redirectPC_q;
    branchCount_d  = branchCount_q;
    mispredCount_d = mispredCount_q;

    if (mispredict) begin
      redirectPC_d = correctPC;
    end

    if (accepted && (branchCount_q != '1)) begin
      branchCount_d = branchCount_q + CNT_WIDTH'(1);
    end

    if (mispredict && (mispredCount_q != '1)) begin
      mispredCount_d = mispredCount_q + CNT_WIDTH'(1);
    end
  end

  // Control registers: FSM state, redirect target and event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      redirectPC_q   <= '0;
      branchCount_q  <= '0;
      mispredCount_q <= '0;
    end else begin
      state_q        <= state_d;
      redirectPC_q   <= redirectPC_d;
      branchCount_q  <= branchCount_d;
      mispredCount_q <= mispredCount_d;
    end
  end

  // Counter table: restored to its initial bias on reset, trained on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrTable_q[i] <= CTR_INIT;
      end
    end else if (accepted) begin
      ctrTable_q[resIdx] <= resCtrNext;
    end
  end

  assign redirectValid = (state_q == REDIRECT);
  assign redirectPC    = redirectPC_q;
  assign branchCount   = branchCount_q;
  assign mispredCount  = mispredCount_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit.
// The driver applies one input vector per cycle, advances a behavioural
// model, and queues what the DUT should show in that cycle; a monitor
// running on the falling edge pops and compares. Expected redirect targets
// are queued separately and consumed whenever the DUT raises redirectValid.

module tb_branch_predict_unit;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IB    = 6;
  localparam int CW    = 4;
  localparam int TBL   = 64;
  localparam int CMAX  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] fetchPC;
  logic          predTaken;
  logic          resValid;
  logic [AW-1:0] resPC;
  logic [1:0]    resBrCode;
  logic [DW-1:0] resRS;
  logic [DW-1:0] resRT;
  logic [15:0]   resDisp;
  logic          resPredTaken;
  logic          redirectValid;
  logic [AW-1:0] redirectPC;
  logic [CW-1:0] branchCount;
  logic [CW-1:0] mispredCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          chkRegs;
    bit          pred;
    bit          rv;
    logic [31:0] rpc;
    int          br;
    int          mis;
  } obs_t;

  obs_t        obsQ[$];
  logic [31:0] redirQ[$];

  // Behavioural model state.
  int          mTable[TBL];
  int          mBr;
  int          mMis;
  bit          mRedir;
  logic [31:0] mRedirPC;
  bit          modelKnown = 1'b0;

  branch_predict_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .INDEX_BITS(IB),
    .CTR_INIT(2'b01),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetchPC(fetchPC),
    .predTaken(predTaken),
    .resValid(resValid),
    .resPC(resPC),
    .resBrCode(resBrCode),
    .resRS(resRS),
    .resRT(resRT),
    .resDisp(resDisp),
    .resPredTaken(resPredTaken),
    .redirectValid(redirectValid),
    .redirectPC(redirectPC),
    .branchCount(branchCount),
    .mispredCount(mispredCount)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd64);
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus: drive, record the expected view, step the model.
  task automatic applyStimulus(input bit r, input logic [31:0] fpc, input bit v,
                               input logic [31:0] rpc, input logic [1:0] code,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [15:0] disp, input bit pt);
    obs_t        o;
    bit          acc;
    bit          tk;
    bit          mis;
    longint      tgt;
    logic [31:0] corr;
    int          i;
    @(posedge clk);
    #1;
    rst          = r;
    fetchPC      = fpc;
    resValid     = v;
    resPC        = rpc;
    resBrCode    = code;
    resRS        = rs;
    resRT        = rt;
    resDisp      = disp;
    resPredTaken = pt;

    o.chkRegs = modelKnown;
    o.pred    = r ? 1'b0 : (mTable[idxOf(fpc)] >= 2);
    o.rv      = mRedir;
    o.rpc     = mRedirPC;
    o.br      = mBr;
    o.mis     = mMis;
    obsQ.push_back(o);

    if (r) begin
      foreach (mTable[k]) mTable[k] = 1;
      mBr        = 0;
      mMis       = 0;
      mRedir     = 1'b0;
      mRedirPC   = '0;
      modelKnown = 1'b1;
    end else if (modelKnown) begin
      acc  = v && (code != 2'd0) && !mRedir;
      tk   = (code == 2'd3) || (code == 2'd1 && rs == rt) || (code == 2'd2 && rs != rt);
      tgt  = longint'(rpc) + 4 + 4 * longint'($signed(disp));
      corr = tk ? 32'(tgt) : 32'(longint'(rpc) + 4);
      mis  = acc && (tk != pt);
      if (acc) begin
        i = idxOf(rpc);
        mTable[i] = tk ? ((mTable[i] < 3) ? mTable[i] + 1 : 3)
                       : ((mTable[i] > 0) ? mTable[i] - 1 : 0);
        mBr = (mBr < CMAX) ? mBr + 1 : CMAX;
      end
      if (mis) begin
        mMis     = (mMis < CMAX) ? mMis + 1 : CMAX;
        mRedirPC = corr;
        redirQ.push_back(corr);
      end
      mRedir = mis;
    end
  endtask

  task automatic idleCycle(input logic [31:0] fpc);
    applyStimulus(1'b0, fpc, 1'b0, 32'h0, 2'd0, 32'h0, 32'h0, 16'h0, 1'b0);
  endtask

  task automatic resolveCycle(input logic [31:0] fpc, input logic [31:0] rpc, input logic [1:0] code,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [15:0] disp, input bit pt);
    applyStimulus(1'b0, fpc, 1'b1, rpc, code, rs, rt, disp, pt);
  endtask

  // Monitor: compare every queued cycle view and every raised redirect.
  always begin : monitor
    obs_t o;
    @(negedge clk);
    if (obsQ.size() > 0) begin
      o = obsQ.pop_front();
      checkOutput("predTaken", predTaken, o.pred);
      if (o.chkRegs) begin
        checkOutput("redirectValid", redirectValid, o.rv);
        checkOutput("redirectPC", redirectPC, o.rpc);
        checkOutput("branchCount", branchCount, o.br);
        checkOutput("mispredCount", mispredCount, o.mis);
        if (redirectValid) begin
          if (redirQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedRedirect actual=0x%0h required=none at %0t", redirectPC, $time);
          end else begin
            checkOutput("redirectTarget", redirectPC, redirQ.pop_front());
          end
        end
      end
    end
  end

  // Main sequence: directed scenarios, then randomized traffic.
  initial begin
    logic [31:0] fpc;
    logic [31:0] rpc;
    bit          r;
    bit          v;
    bit          pt;
    logic [1:0]  code;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] disp;

    rst = 1'b1; fetchPC = '0; resValid = 1'b0; resPC = '0; resBrCode = '0;
    resRS = '0; resRT = '0; resDisp = '0; resPredTaken = 1'b0;

    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 2'd0, 32'h0, 32'h0, 16'h0, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 2'd0, 32'h0, 32'h0, 16'h0, 1'b0);

    idleCycle(32'h40);
    @(negedge clk);
    checkOutput("resetPred", predTaken, 0);
    checkOutput("resetBranchCount", branchCount, 0);
    checkOutput("resetRedirect", redirectValid, 0);

    // EQ mispredict at 0x40: target 0x44 + 3*4.
    resolveCycle(32'h40, 32'h40, 2'd1, 32'd5, 32'd5, 16'h0003, 1'b0);
    idleCycle(32'h40);
    @(negedge clk);
    checkOutput("eqRedirectValid", redirectValid, 1);
    checkOutput("eqRedirectPC", redirectPC, 32'h50);
    checkOutput("eqMispredCount", mispredCount, 1);
    checkOutput("eqTrainedPred", predTaken, 1);

    // NE not taken twice at 0x100: counter bottoms out.
    resolveCycle(32'h100, 32'h100, 2'd2, 32'd7, 32'd7, 16'h0, 1'b0);
    resolveCycle(32'h100, 32'h100, 2'd2, 32'd7, 32'd7, 16'h0, 1'b0);
    idleCycle(32'h100);
    @(negedge clk);
    checkOutput("neBranchCount", branchCount, 3);
    checkOutput("neNoRedirect", redirectValid, 0);

    // TAKEN with negative displacement, then a wrong-path resolve.
    resolveCycle(32'h100, 32'h100, 2'd3, 32'd0, 32'd0, 16'hFFFE, 1'b0);
    resolveCycle(32'h100, 32'h100, 2'd1, 32'd1, 32'd1, 16'h0010, 1'b0);
    @(negedge clk);
    checkOutput("takenRedirectPC", redirectPC, 32'hFC);
    checkOutput("takenRedirectValid", redirectValid, 1);
    idleCycle(32'h100);
    @(negedge clk);
    checkOutput("droppedRedirect", redirectValid, 0);
    checkOutput("droppedBranchCount", branchCount, 4);
    checkOutput("droppedMispredCount", mispredCount, 2);
    checkOutput("droppedTablePred", predTaken, 0);

    // Four taken EQ at 0x40, then walk back down to check saturation at 3.
    for (int k = 0; k < 4; k++) begin
      resolveCycle(32'h140, 32'h40, 2'd1, 32'd9, 32'd9, 16'h0001, 1'b1);
    end
    idleCycle(32'h140);
    @(negedge clk);
    checkOutput("aliasPred", predTaken, 1);
    checkOutput("satBranchCount8", branchCount, 8);
    resolveCycle(32'h140, 32'h40, 2'd1, 32'd1, 32'd2, 16'h0001, 1'b0);
    idleCycle(32'h140);
    @(negedge clk);
    checkOutput("ctrDownOnce", predTaken, 1);
    resolveCycle(32'h140, 32'h40, 2'd1, 32'd1, 32'd2, 16'h0001, 1'b0);
    idleCycle(32'h140);
    @(negedge clk);
    checkOutput("ctrDownTwice", predTaken, 0);

    // Push branchCount into saturation.
    for (int k = 0; k < 8; k++) begin
      resolveCycle(32'h200, 32'h200, 2'd2, 32'd1, 32'd2, 16'h0002, 1'b1);
    end
    idleCycle(32'h200);
    @(negedge clk);
    checkOutput("branchCountSat", branchCount, CMAX);
    checkOutput("mispredHold", mispredCount, 2);

    // Mispredict followed immediately by reset.
    resolveCycle(32'h40, 32'h40, 2'd1, 32'd1, 32'd2, 16'h0004, 1'b1);
    applyStimulus(1'b1, 32'h200, 1'b0, 32'h0, 2'd0, 32'h0, 32'h0, 16'h0, 1'b0);
    @(negedge clk);
    checkOutput("rstCycleRedirect", redirectValid, 1);
    checkOutput("rstCyclePredForced", predTaken, 0);
    idleCycle(32'h40);
    @(negedge clk);
    checkOutput("postRstRedirect", redirectValid, 0);
    checkOutput("postRstBranchCount", branchCount, 0);
    checkOutput("postRstMispredCount", mispredCount, 0);
    checkOutput("postRstPred", predTaken, 0);

    // Randomized traffic with aliasing PCs and occasional reset.
    for (int k = 0; k < 600; k++) begin
      r    = ($urandom_range(0, 149) == 0);
      fpc  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      rpc  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      v    = ($urandom_range(0, 3) != 0);
      code = 2'($urandom_range(0, 3));
      rs   = 32'($urandom_range(0, 2));
      rt   = 32'($urandom_range(0, 2));
      disp = 16'($urandom);
      pt   = ($urandom_range(0, 1) == 1) ? (mTable[idxOf(rpc)] >= 2) : 1'($urandom_range(0, 1));
      applyStimulus(r, fpc, v, rpc, code, rs, rt, disp, pt);
    end

    idleCycle(32'h0);
    idleCycle(32'h0);
    idleCycle(32'h0);
    @(negedge clk);
    #1;
    checkOutput("redirQueueDrained", redirQ.size(), 0);
    checkOutput("obsQueueDrained", obsQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
